// File: rtl/edge_interval_meter_if.sv
// -----------------------------------------------------------------------------
// edge_interval_meter_if
//   Valid/ready stream carrying {polarity, interval} records out of
//   edge_interval_meter.
//
//   m_data   record at the head of the FIFO: [CNT_W] = polarity, [CNT_W-1:0] = interval
//   m_valid  a record is available
//   m_ready  the consumer takes the head when m_valid & m_ready
//
//   master : the producer (edge_interval_meter)
//   slave  : the consumer
// -----------------------------------------------------------------------------
interface edge_interval_meter_if #(
    parameter int CNT_W = 16
) ();
    logic [CNT_W:0] m_data;
    logic           m_valid;
    logic           m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/edge_interval_meter.sv
// -----------------------------------------------------------------------------
// edge_interval_meter
//   Measures the number of clock cycles between consecutive edge pulses from
//   the dual-edge detector. Each measured interval is tagged with the polarity
//   of the edge that closed it and pushed into a small first-word-fall-through
//   FIFO. Records that arrive while the FIFO is full are counted and dropped.
//
// Parameters
//   CNT_W  interval counter / interval field width (saturating)
//   DEPTH  FIFO entries, power of two, >= 2
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   clr         synchronous soft clear, same effect as rst
//   edge_pulse  one-cycle pulse per detected edge
//   lvl_in      signal level after the edge (sampled on the pulse cycle)
//   m_if        output record stream (master side)
//   drop_cnt    records lost to a full FIFO, saturates at 255
//   armed       a reference edge has been seen (state RUN)
// -----------------------------------------------------------------------------
module edge_interval_meter #(
    parameter int CNT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        edge_pulse,
    input  logic                        lvl_in,
    edge_interval_meter_if.master       m_if,
    output logic [7:0]                  drop_cnt,
    output logic                        armed
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;

    logic [CNT_W:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [CNT_W:0]   r_data;
    logic             r_valid;
    logic [7:0]       r_drop;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             w_sync_clr;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_rec_vld;
    logic [CNT_W:0]   w_rec;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [AW-1:0]    w_rd_ptr_n;
    logic [AW:0]      w_count_n;
    logic [CNT_W:0]   w_head_n;

    assign w_sync_clr = rst | clr;

    // Saturating increment: a very long gap reports the maximum instead of
    // wrapping to a misleadingly small interval.
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);

    // A record exists only for the second and later edges.
    assign w_rec_vld  = (r_state == RUN) && edge_pulse;
    assign w_rec      = {lvl_in, w_cnt_inc};

    assign w_full     = (r_count == OCC_FULL);
    // m_ready is the only input allowed to reach logic combinationally; it
    // only steers the pop, never an output directly.
    assign w_pop      = r_valid & m_if.m_ready;
    // A pop on the same cycle frees the slot, so a push at full still lands.
    assign w_push     = w_rec_vld & (~w_full | w_pop);
    assign w_drop     = w_rec_vld & w_full & ~w_pop;

    always_comb begin
        w_rd_ptr_n = r_rd_ptr;
        if (w_pop)
            w_rd_ptr_n = r_rd_ptr + PTR_ONE;
    end

    always_comb begin
        w_count_n = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_n = r_count + OCC_ONE;
            2'b01:   w_count_n = r_count - OCC_ONE;
            default: w_count_n = r_count;
        endcase
    end

    // Next head of queue. If the slot about to become the head is the one
    // being written this cycle (FIFO empty after any pop), the new record
    // bypasses the memory; otherwise the stored entry is already valid.
    always_comb begin
        w_head_n = r_mem[w_rd_ptr_n];
        if (w_push && (r_wr_ptr == w_rd_ptr_n))
            w_head_n = w_rec;
    end

    // ------------------------------------------------------------------
    // FSM and interval counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_sync_clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    // First edge only establishes the reference point.
                    if (edge_pulse) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                        r_armed <= 1'b1;
                    end
                end
                RUN: begin
                    if (edge_pulse)
                        r_cnt <= '0;
                    else
                        r_cnt <= w_cnt_inc;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage: no reset needed, entries are only read after a write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push && !w_sync_clr)
            r_mem[r_wr_ptr] <= w_rec;
    end

    // ------------------------------------------------------------------
    // FIFO control, registered head and drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_sync_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_drop   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            r_rd_ptr <= w_rd_ptr_n;
            r_count  <= w_count_n;
            r_valid  <= (w_count_n != '0);
            // Head register keeps its last value while the FIFO is empty.
            if (w_count_n != '0)
                r_data <= w_head_n;
            if (w_drop && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign m_if.m_data  = r_data;
    assign m_if.m_valid = r_valid;
    assign drop_cnt     = r_drop;
    assign armed        = r_armed;

endmodule

// File: tb/tb_edge_interval_meter.sv
// -----------------------------------------------------------------------------
// tb_edge_interval_meter
//   Directed vector table, hand-written corner sequences and a randomized run.
//   Every cycle is also compared against a cycle-indexed queue model: it
//   remembers the cycle number of the last edge, computes intervals as a
//   plain subtraction capped at 2^CNT_W-1, and keeps records in a queue.
// -----------------------------------------------------------------------------
module tb_edge_interval_meter;

    localparam int CNT_W = 4;
    localparam int DEPTH = 4;
    localparam int IMAX  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       edge_pulse = 1'b0;
    logic       lvl_in = 1'b0;
    logic [7:0] drop_cnt;
    logic       armed;

    edge_interval_meter_if #(.CNT_W(CNT_W)) s_if ();

    edge_interval_meter #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .edge_pulse (edge_pulse),
        .lvl_in     (lvl_in),
        .m_if       (s_if.master),
        .drop_cnt   (drop_cnt),
        .armed      (armed)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    int             m_cyc  = 0;
    int             m_last = 0;
    bit             m_armed = 1'b0;
    logic [CNT_W:0] m_q [$];
    int             m_drop = 0;
    logic [CNT_W:0] m_data = '0;

    task automatic model_edge(input logic rs, cl, ep, lv, rd);
        bit pop;
        int iv;
        if (rs || cl) begin
            m_armed = 1'b0;
            m_q.delete();
            m_drop  = 0;
            m_data  = '0;
        end else begin
            pop = (m_q.size() > 0) && rd;
            iv  = m_cyc - m_last;
            if (iv > IMAX) iv = IMAX;
            if (pop) void'(m_q.pop_front());
            if (m_armed && ep) begin
                if (m_q.size() < DEPTH) m_q.push_back({lv, iv[CNT_W-1:0]});
                else if (m_drop < 255) m_drop++;
            end
            if (ep) begin
                m_last  = m_cyc;
                m_armed = 1'b1;
            end
            if (m_q.size() > 0) m_data = m_q[0];
        end
        m_cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, update the model, compare.
    task automatic step(input logic rs, cl, ep, lv, rd);
        rst = rs; clr = cl; edge_pulse = ep; lvl_in = lv; s_if.m_ready = rd;
        @(posedge clk);
        model_edge(rs, cl, ep, lv, rd);
        #1;
        chk("model armed", 32'(armed), 32'(m_armed));
        chk("model valid", 32'(s_if.m_valid), 32'(m_q.size() > 0));
        chk("model data",  32'(s_if.m_data), 32'(m_data));
        chk("model drop",  32'(drop_cnt), 32'(m_drop));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic           rs, cl, ep, lv, rd;
        logic           ev;
        logic [CNT_W:0] ed;
        logic [7:0]     edr;
        logic           ea;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.m_ready = 1'b0;

        //           rs cl ep lv rd   ev  ed      drop ea
        tbl[0]  = '{1, 0, 1, 1, 0,   0, 5'h00, 8'd0, 0};  // reset, pulse ignored
        tbl[1]  = '{1, 0, 0, 0, 1,   0, 5'h00, 8'd0, 0};
        tbl[2]  = '{0, 0, 0, 0, 1,   0, 5'h00, 8'd0, 0};  // not armed without pulse
        tbl[3]  = '{0, 0, 0, 0, 1,   0, 5'h00, 8'd0, 0};
        tbl[4]  = '{0, 0, 1, 1, 1,   0, 5'h00, 8'd0, 1};  // arm, no record
        tbl[5]  = '{0, 0, 0, 0, 1,   0, 5'h00, 8'd0, 1};
        tbl[6]  = '{0, 0, 0, 0, 1,   0, 5'h00, 8'd0, 1};
        tbl[7]  = '{0, 0, 0, 0, 1,   0, 5'h00, 8'd0, 1};
        tbl[8]  = '{0, 0, 0, 0, 1,   0, 5'h00, 8'd0, 1};
        tbl[9]  = '{0, 0, 1, 0, 1,   1, 5'h05, 8'd0, 1};  // interval 5, falling
        tbl[10] = '{0, 0, 1, 1, 1,   1, 5'h11, 8'd0, 1};  // back-to-back {1,1}
        tbl[11] = '{0, 0, 1, 0, 1,   1, 5'h01, 8'd0, 1};  // {0,1}
        tbl[12] = '{0, 0, 1, 1, 1,   1, 5'h11, 8'd0, 1};  // {1,1}
        tbl[13] = '{0, 0, 0, 0, 1,   0, 5'h11, 8'd0, 1};  // drained, data held
        tbl[14] = '{0, 0, 0, 0, 0,   0, 5'h11, 8'd0, 1};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rs, tbl[i].cl, tbl[i].ep, tbl[i].lv, tbl[i].rd);
            chk($sformatf("vec%0d valid", i), 32'(s_if.m_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d data", i),  32'(s_if.m_data),  32'(tbl[i].ed));
            chk($sformatf("vec%0d drop", i),  32'(drop_cnt),     32'(tbl[i].edr));
            chk($sformatf("vec%0d armed", i), 32'(armed),        32'(tbl[i].ea));
        end

        // ---------------- saturation ----------------
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);                        // arm
        repeat (19) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);                        // 20 cycles later
        chk("sat valid", 32'(s_if.m_valid), 32'd1);
        chk("sat data",  32'(s_if.m_data),  32'h0F);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 1);                        // 3 cycles later
        chk("sat next data", 32'(s_if.m_data), 32'h13);

        // ---------------- overflow ----------------
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);                        // arm
        for (int g = 2; g <= 7; g++) begin
            repeat (g - 1) step(0, 0, 0, 0, 0);
            step(0, 0, 1, 1'(g & 1), 0);
        end
        chk("ovf drop",  32'(drop_cnt), 32'd2);
        chk("ovf valid", 32'(s_if.m_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf drain%0d", k), 32'(s_if.m_data),
                32'({1'((k + 2) & 1), 4'(k + 2)}));
            step(0, 0, 0, 0, 1);
        end
        chk("ovf empty", 32'(s_if.m_valid), 32'd0);
        repeat (4) step(0, 0, 1, 1, 0);             // refill to full
        step(0, 0, 1, 0, 1);                        // push + pop at full
        chk("ovf pop+push drop", 32'(drop_cnt), 32'd2);
        chk("ovf pop+push valid", 32'(s_if.m_valid), 32'd1);

        // ---------------- clear mid-operation ----------------
        step(0, 0, 0, 0, 1);                        // 3 records remain
        step(0, 1, 1, 1, 0);                        // clr wins over pulse
        chk("clr valid", 32'(s_if.m_valid), 32'd0);
        chk("clr drop",  32'(drop_cnt), 32'd0);
        chk("clr armed", 32'(armed), 32'd0);
        step(0, 0, 1, 1, 0);                        // re-arm only
        chk("clr rearm armed", 32'(armed), 32'd1);
        chk("clr rearm valid", 32'(s_if.m_valid), 32'd0);
        step(0, 0, 1, 0, 0);
        chk("clr first rec", 32'(s_if.m_data), 32'h01);

        // ---------------- randomized ----------------
        step(1, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            step(1'b0,
                 1'($urandom_range(0, 149) == 0),
                 1'($urandom_range(0, 99) < 40),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < 45));
            if ((n % 97) == 96)
                repeat (18) step(0, 0, 0, 0, 0);    // long gaps to hit saturation
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
